// File: rtl/cdc_sync_bank.sv
// rtl/cdc_sync_bank.sv - multi-channel bus synchroniser with stability filter
// Each channel's output word only moves once its synchronised value has held steady.
module cdc_sync_bank #(
   parameter int                 CHANNELS      = 4,
   parameter int                 WIDTH         = 16,
   parameter int                 STAGES        = 2,
   parameter int                 STABLE_CYCLES = 3,
   parameter logic [WIDTH-1:0]   RESET_VALUE   = '0
) (
   input  logic                      dst_clk,
   input  logic                      dst_rst,
   input  logic [CHANNELS*WIDTH-1:0] async_data,
   input  logic [CHANNELS-1:0]       freeze,
   output logic [CHANNELS*WIDTH-1:0] dst_data,
   output logic [CHANNELS-1:0]       dst_valid,
   output logic [CHANNELS-1:0]       dst_stable,
   output logic [15:0]               drop_count
);

   localparam logic [7:0] STABLE_C  = 8'(STABLE_CYCLES);
   localparam logic [7:0] UPDATE_AT = 8'(STABLE_CYCLES - 1);

   logic [CHANNELS-1:0] drop;
   logic [31:0]         drop_num;
   logic [31:0]         drop_sum;

   for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
      logic [WIDTH-1:0] chain [STAGES];
      logic [WIDTH-1:0] cand_q;
      logic [WIDTH-1:0] data_q;
      logic [7:0]       cnt_q;
      logic [7:0]       cnt_nxt;
      logic             valid_q;
      logic             stable_q;
      logic             match;
      logic             update;

      assign match  = (chain[STAGES-1] == cand_q);
      assign update = match && (cnt_q >= UPDATE_AT) && !freeze[n] && (cand_q != data_q);
      // A candidate abandoned before it qualified, and different from the output, is a drop.
      assign drop[n] = !match && (cand_q != data_q) && (cnt_q < STABLE_C);
      assign cnt_nxt = !match ? 8'd0 : ((cnt_q == STABLE_C) ? cnt_q : cnt_q + 8'd1);

      always_ff @(posedge dst_clk or posedge dst_rst) begin
         if (dst_rst) begin
            for (int k = 0; k < STAGES; k++) chain[k] <= RESET_VALUE;
            cand_q   <= RESET_VALUE;
            data_q   <= RESET_VALUE;
            cnt_q    <= 8'd0;
            valid_q  <= 1'b0;
            stable_q <= 1'b0;
         end else begin
            chain[0] <= async_data[n*WIDTH +: WIDTH];
            for (int k = 1; k < STAGES; k++) chain[k] <= chain[k-1];
            if (!match) cand_q <= chain[STAGES-1];
            cnt_q    <= cnt_nxt;
            stable_q <= (cnt_nxt == STABLE_C);
            valid_q  <= update;
            if (update) data_q <= cand_q;
         end
      end

      assign dst_data[n*WIDTH +: WIDTH] = data_q;
      assign dst_valid[n]               = valid_q;
      assign dst_stable[n]              = stable_q;
   end

   always_comb begin
      drop_num = 32'd0;
      for (int n = 0; n < CHANNELS; n++) drop_num = drop_num + 32'(drop[n]);
   end

   assign drop_sum = {16'd0, drop_count} + drop_num;

   always_ff @(posedge dst_clk or posedge dst_rst) begin
      if (dst_rst)                 drop_count <= 16'd0;
      else if (drop_sum > 32'hFFFF) drop_count <= 16'hFFFF;
      else                         drop_count <= drop_sum[15:0];
   end

endmodule

// File: tb/tb_cdc_sync_bank.sv
// tb/tb_cdc_sync_bank.sv - randomized and directed checks of cdc_sync_bank against a reference model
module tb_cdc_sync_bank;
   localparam int CH = 4;
   localparam int W  = 16;
   localparam int ST = 2;
   localparam int SC = 3;

   logic            dst_clk = 1'b0;
   logic            dst_rst = 1'b1;
   logic [CH*W-1:0] async_data = '0;
   logic [CH-1:0]   freeze = '0;
   logic [CH*W-1:0] dst_data;
   logic [CH-1:0]   dst_valid;
   logic [CH-1:0]   dst_stable;
   logic [15:0]     drop_count;

   int n_cmp = 0;
   int n_bad = 0;

   cdc_sync_bank #(.CHANNELS(CH), .WIDTH(W), .STAGES(ST), .STABLE_CYCLES(SC), .RESET_VALUE('0)) dut (
      .dst_clk(dst_clk), .dst_rst(dst_rst), .async_data(async_data), .freeze(freeze),
      .dst_data(dst_data), .dst_valid(dst_valid), .dst_stable(dst_stable), .drop_count(drop_count)
   );

   always #5 dst_clk = ~dst_clk;

   // Reference model: history queue of sampled inputs plus per-channel filter state.
   logic [W-1:0] m_q [CH][$];
   logic [W-1:0] m_cand [CH];
   logic [W-1:0] m_data [CH];
   int           m_cnt [CH];
   bit           m_valid [CH];
   bit           m_stable [CH];
   int           m_drop;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int n = 0; n < CH; n++) begin
         m_q[n] = {};
         for (int k = 0; k < ST; k++) m_q[n].push_back('0);
         m_cand[n] = '0; m_data[n] = '0; m_cnt[n] = 0;
         m_valid[n] = 0; m_stable[n] = 0;
      end
      m_drop = 0;
   endtask

   task automatic model_step();
      int ndrop = 0;
      for (int n = 0; n < CH; n++) begin
         logic [W-1:0] sl;
         bit upd;
         sl = m_q[n].pop_front();
         m_q[n].push_back(async_data[n*W +: W]);
         upd = (sl == m_cand[n]) && (m_cnt[n] >= SC - 1) && !freeze[n] && (m_cand[n] != m_data[n]);
         if (sl != m_cand[n]) begin
            if (m_cand[n] != m_data[n] && m_cnt[n] < SC) ndrop++;
            m_cand[n] = sl;
            m_cnt[n]  = 0;
         end else begin
            m_cnt[n] = (m_cnt[n] + 1 > SC) ? SC : m_cnt[n] + 1;
         end
         if (upd) m_data[n] = m_cand[n];
         m_valid[n]  = upd;
         m_stable[n] = (m_cnt[n] == SC);
      end
      m_drop = (m_drop + ndrop > 65535) ? 65535 : m_drop + ndrop;
   endtask

   task automatic compare_all();
      logic [CH*W-1:0] ed;
      logic [CH-1:0]   ev, es;
      for (int n = 0; n < CH; n++) begin
         ed[n*W +: W] = m_data[n];
         ev[n] = m_valid[n];
         es[n] = m_stable[n];
      end
      check("dst_data", 64'(dst_data), 64'(ed));
      check("dst_valid", 64'(dst_valid), 64'(ev));
      check("dst_stable", 64'(dst_stable), 64'(es));
      check("drop_count", 64'(drop_count), 64'(m_drop));
   endtask

   task automatic tick(input bit cmp = 1);
      @(posedge dst_clk);
      if (!dst_rst) model_step();
      #1;
      if (cmp) compare_all();
   endtask

   task automatic set_ch(input int n, input logic [W-1:0] v);
      async_data[n*W +: W] = v;
   endtask

   logic [15:0] drop_before;
   logic [15:0] ch3_before;

   initial begin
      model_reset();
      repeat (3) tick(0);
      dst_rst = 1'b0;

      // Idle after reset
      check("reset_data", 64'(dst_data), 64'd0);
      check("reset_valid", 64'(dst_valid), 64'd0);
      check("reset_stable", 64'(dst_stable), 64'd0);
      check("reset_drop", 64'(drop_count), 64'd0);
      repeat (20) tick();

      // ch0 settles to A5A5 after six edges
      set_ch(0, 16'hA5A5);
      repeat (5) tick();
      check("ch0_before", 64'(dst_data[15:0]), 64'h0000);
      tick();
      check("ch0_data", 64'(dst_data[15:0]), 64'hA5A5);
      check("ch0_valid", 64'(dst_valid), 64'b0001);
      check("ch0_stable", 64'(dst_stable[0]), 64'd1);
      check("ch0_others", 64'(dst_data[63:16]), 64'd0);
      tick();
      check("ch0_valid_once", 64'(dst_valid), 64'd0);
      repeat (4) tick();

      // ch1 two-cycle glitch is rejected
      drop_before = drop_count;
      set_ch(1, 16'h1234);
      repeat (2) tick();
      set_ch(1, 16'h0000);
      repeat (10) tick();
      check("ch1_glitch_data", 64'(dst_data[31:16]), 64'h0000);
      check("ch1_glitch_drop", 64'(drop_count), 64'(drop_before) + 64'd1);

      // ch2 held by freeze, then released
      freeze[2] = 1'b1;
      set_ch(2, 16'hBEEF);
      repeat (10) tick();
      check("ch2_frozen", 64'(dst_data[47:32]), 64'h0000);
      freeze[2] = 1'b0;
      tick();
      check("ch2_release", 64'(dst_data[47:32]), 64'hBEEF);
      check("ch2_pulse", 64'(dst_valid), 64'b0100);
      tick();
      check("ch2_pulse_once", 64'(dst_valid), 64'd0);

      // All channels change together
      async_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      repeat (6) tick();
      check("all_data", 64'(dst_data), 64'h4444_3333_2222_1111);
      check("all_valid", 64'(dst_valid), 64'b1111);
      tick();
      check("all_valid_once", 64'(dst_valid), 64'd0);

      // Random held values, glitches and freezes
      repeat (400) begin
         for (int n = 0; n < CH; n++)
            if ($urandom_range(0, 2) == 0) set_ch(n, W'($urandom_range(0, 7)) * 16'h1111);
         freeze = CH'($urandom_range(0, 15) & $urandom_range(0, 15));
         repeat ($urandom_range(1, 8)) tick();
      end
      freeze = '0;
      repeat (10) tick();

      // Reset in the middle of a count
      set_ch(0, 16'h5A5A ^ dst_data[15:0]);
      repeat (4) tick();
      @(posedge dst_clk);
      #1 dst_rst = 1'b1;
      #1;
      check("midrst_data", 64'(dst_data), 64'd0);
      check("midrst_valid", 64'(dst_valid), 64'd0);
      check("midrst_stable", 64'(dst_stable), 64'd0);
      check("midrst_drop", 64'(drop_count), 64'd0);
      model_reset();
      repeat (2) tick(0);
      dst_rst = 1'b0;
      repeat (10) tick();

      // ch3 toggles every cycle: never updates, drop count saturates
      ch3_before = dst_data[63:48];
      for (int i = 0; i < 70000; i++) begin
         set_ch(3, (i % 2 == 0) ? 16'h0001 : 16'h0002);
         tick();
      end
      check("ch3_hold", 64'(dst_data[63:48]), 64'(ch3_before));
      check("drop_saturate", 64'(drop_count), 64'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cdc_sync_bank.md
Name: cdc_sync_bank

Overview:
- Multi-channel, parametrised destination-side synchroniser for quasi-static multi-bit buses arriving from an unrelated clock domain.
- Each channel runs its bus through a STAGES-deep flop chain, then a stability filter.
- A channel's output updates atomically only after the synchronised value has held unchanged for STABLE_CYCLES consecutive cycles. This removes the torn-word hazard of a plain per-bit 2-FF bus sync.
- Sits at the destination edge of membridge, replacing per-bus raw synchronisers for config and status words.

Parameters:
- CHANNELS, 4: number of independent bus channels.
- WIDTH, 16: bits per channel.
- STAGES, 2: synchroniser flop depth, legal range 2..4.
- STABLE_CYCLES, 3: consecutive matching cycles required before update, legal range 1..255.
- RESET_VALUE, 0: WIDTH-bit value loaded into every sync flop, candidate and output on reset.

Ports:
- dst_clk  input  1  destination clock; the only clock.
- dst_rst  input  1  asynchronous, active-high reset.
- async_data  input  CHANNELS*WIDTH  source buses, channel n at bits [n*WIDTH +: WIDTH]; no timing relation to dst_clk.
- freeze  input  CHANNELS  per-channel hold; while high, dst_data[n] does not update.
- dst_data  output  CHANNELS*WIDTH  filtered, synchronised buses.
- dst_valid  output  CHANNELS  one-cycle pulse per channel when dst_data[n] takes a new value.
- dst_stable  output  CHANNELS  level: channel candidate has met the stability requirement.
- drop_count  output  16  saturating count of rejected candidates, all channels.

Behaviour:
- Reset (async assert, released synchronously by the environment):
  - sync flops, cand and dst_data = RESET_VALUE.
  - cnt = 0; dst_valid = 0; dst_stable = 0; drop_count = 0.
- Per channel, every dst_clk edge:
  - Sync chain: s[0] <= async_data[n], s[k] <= s[k-1]. Let sl = s[STAGES-1].
  - Mismatch (sl != cand):
    - cand <= sl; cnt <= 0.
    - If cand != dst_data[n] and cnt < STABLE_CYCLES, the old candidate was rejected: drop_count += 1, saturating at 0xFFFF.
  - Match (sl == cand): cnt <= min(cnt+1, STABLE_CYCLES).
  - Update condition: match AND cnt >= STABLE_CYCLES-1 AND freeze[n]==0 AND cand != dst_data[n].
    - When true: dst_data[n] <= cand, dst_valid[n] <= 1.
    - Otherwise dst_valid[n] <= 0.
  - dst_stable[n] is registered, equal to (cnt == STABLE_CYCLES).
- Drop counting when several channels drop on the same edge: drop_count adds the number of dropping channels, with one saturating add.
- Latency: async_data steady before edge 0 gives dst_data updated after edge STAGES+1+STABLE_CYCLES (6 with defaults). dst_valid is high during the following cycle.
- Glitch shorter than STABLE_CYCLES+1 cycles, returning to the old value: no dst_data change, no dst_valid, drop_count +1.
- Freeze:
  - Raised mid-count: counting continues, output holds.
  - Released while stable with cand != dst_data: update on the first edge where freeze==0.
- cand == dst_data when stable: no pulse. Repeated stable cycles never re-pulse.
- Channels are fully independent; simultaneous updates on multiple channels are allowed.
- Reset mid-count: everything returns to reset state immediately; no dst_valid pulse on exit.

Test Plan:
- Reset then idle, defaults: dst_data = 0, dst_valid = 0, dst_stable = 0 for 20 cycles; assert dst_rst mid-run -> outputs are 0 before the next edge.
- ch0 async 0x0000 -> 0xA5A5 held: dst_data[0] = 0xA5A5 after edge 6, dst_valid[0] high exactly one cycle, dst_stable[0] high from edge 6, other channels untouched.
- ch1 0x0000 -> 0x1234 for 2 cycles, then back to 0x0000: dst_data[1] stays 0, no dst_valid, drop_count = 1.
- ch2 freeze=1, input -> 0xBEEF for 10 cycles: dst_data[2] = 0; drop freeze -> dst_data[2] = 0xBEEF on the next edge, single dst_valid pulse.
- All 4 channels change on the same edge to 0x1111/0x2222/0x3333/0x4444: all update on the same edge, dst_valid = 4'b1111 for one cycle.
- Alternate ch3 between 0x0001 and 0x0002 every cycle for 70000 cycles: dst_data[3] never changes, drop_count saturates at 0xFFFF.
